// File: rtl/cnt_int_ctrl_if.sv
// cnt_int_ctrl_if: interrupt controller bus between CPU/counter side and the controller
interface cnt_int_ctrl_if #(
  parameter int NCH = 4,
  parameter int IDW = 2
);
  logic [NCH-1:0] int_in;
  logic           mask_wr;
  logic [NCH-1:0] mask_wdata;
  logic [NCH-1:0] ovf_clr;
  logic           irq_ack;
  logic [NCH-1:0] mask;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] ovf;
  logic           irq;
  logic [IDW-1:0] irq_id;
  modport master (
    output int_in, mask_wr, mask_wdata, ovf_clr, irq_ack,
    input  mask, pend, ovf, irq, irq_id
  );
  modport slave (
    input  int_in, mask_wr, mask_wdata, ovf_clr, irq_ack,
    output mask, pend, ovf, irq, irq_id
  );
endinterface

// File: rtl/cnt_int_ctrl.sv
// cnt_int_ctrl: aggregates counter-channel int levels into a round-robin served CPU interrupt
module cnt_int_ctrl #(
  parameter int NCH = 4,
  parameter int IDW = 2
) (
  input  logic          clk,
  input  logic          xrst,
  cnt_int_ctrl_if.slave b
);
  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;
  state_t         state, state_nx;
  logic [NCH-1:0] int_d, pend, ovf, mask, edg, elig, clr;
  logic [IDW-1:0] last, irq_id, sel, idx;
  logic           found, ack;
  assign edg  = b.int_in & ~int_d & ~mask;
  assign elig = pend & ~mask;
  assign ack  = state == ASSERT && b.irq_ack;
  assign clr  = ack ? NCH'(1) << irq_id : '0;
  assign b.mask   = mask;
  assign b.pend   = pend;
  assign b.ovf    = ovf;
  assign b.irq    = state == ASSERT;
  assign b.irq_id = irq_id;
  // round-robin pick: first eligible channel at or after last+1, wrapping
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = IDW'((int'(last) + 1 + k) % NCH);
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
  // next state: serve when something is eligible, hold until ack, one idle gap cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = ASSERT;
      ASSERT:  if (b.irq_ack) state_nx = GAP;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) state <= IDLE;
    else       state <= state_nx;
  // edge history, pending/overrun flags, mask, served-channel bookkeeping
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) begin
      int_d  <= '0;
      pend   <= '0;
      ovf    <= '0;
      mask   <= '1;
      last   <= IDW'(NCH - 1);
      irq_id <= '0;
    end else begin
      int_d <= b.int_in;
      pend  <= (pend & ~clr) | edg;
      ovf   <= (ovf & ~b.ovf_clr) | (edg & pend & ~clr);
      if (b.mask_wr) mask <= b.mask_wdata;
      if (state == IDLE && found) irq_id <= sel;
      if (ack) last <= irq_id;
    end
endmodule

// File: tb/tb_cnt_int_ctrl.sv
// tb_cnt_int_ctrl: directed checks of pend/ovf/mask handling and round-robin irq service
module tb_cnt_int_ctrl;
  logic       clk = 1'b0;
  logic       xrst;
  int         total = 0;
  int         bad = 0;
  logic [3:0] e;
  cnt_int_ctrl_if #(.NCH(4), .IDW(2)) b();
  cnt_int_ctrl #(.NCH(4), .IDW(2)) dut (.clk(clk), .xrst(xrst), .b(b.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    xrst = 1'b0;
    b.int_in = '0; b.mask_wr = 1'b0; b.mask_wdata = '0; b.ovf_clr = '0; b.irq_ack = 1'b0;
    tick; tick;
    chk("rst_mask", b.mask, 4'hf);
    chk("rst_pend", b.pend, 4'h0);
    chk("rst_ovf", b.ovf, 4'h0);
    chk("rst_irq", b.irq, 1'b0);
    chk("rst_id", b.irq_id, 2'd0);
    xrst = 1'b1;
    // masked channel pulse is ignored
    b.int_in = 4'b0001; tick; b.int_in = 4'b0000; tick;
    chk("masked_pend", b.pend, 4'h0);
    chk("masked_irq", b.irq, 1'b0);
    b.mask_wr = 1'b1; b.mask_wdata = 4'b1110; tick; b.mask_wr = 1'b0;
    chk("mask_wr", b.mask, 4'he);
    b.int_in = 4'b1000; tick; tick;
    chk("held_masked", b.pend, 4'h0);
    b.int_in = 4'b1001; tick;
    chk("ch0_pend", b.pend, 4'h1);
    chk("ch0_irq_lat", b.irq, 1'b0);
    b.int_in = 4'b1000; tick;
    chk("ch0_irq", b.irq, 1'b1);
    chk("ch0_id", b.irq_id, 2'd0);
    b.int_in = 4'b0000; b.irq_ack = 1'b1; tick; b.irq_ack = 1'b0;
    chk("ch0_ack_pend", b.pend, 4'h0);
    chk("ch0_gap_irq", b.irq, 1'b0);
    tick;
    chk("ch0_idle_irq", b.irq, 1'b0);
    b.mask_wr = 1'b1; b.mask_wdata = 4'b0000; tick; b.mask_wr = 1'b0;
    // single event on channel 2
    b.int_in = 4'b0100; tick; b.int_in = 4'b0000;
    chk("se_pend", b.pend, 4'h4);
    chk("se_irq_lat", b.irq, 1'b0);
    tick;
    chk("se_irq", b.irq, 1'b1);
    chk("se_id", b.irq_id, 2'd2);
    b.irq_ack = 1'b1; tick; b.irq_ack = 1'b0;
    chk("se_ack_pend", b.pend, 4'h0);
    chk("se_gap_irq", b.irq, 1'b0);
    tick;
    chk("se_idle_irq", b.irq, 1'b0);
    // service channel 3 so the round-robin pointer sits at 3
    b.int_in = 4'b1000; tick; b.int_in = 4'b0000; tick;
    chk("ch3_id", b.irq_id, 2'd3);
    b.irq_ack = 1'b1; tick; b.irq_ack = 1'b0; tick;
    // round robin, twice
    for (int r = 0; r < 2; r++) begin
      b.int_in = 4'b1111; tick; b.int_in = 4'b0000;
      chk("rr_pend_all", b.pend, 4'hf);
      tick;
      for (int j = 0; j < 4; j++) begin
        chk("rr_irq", b.irq, 1'b1);
        chk("rr_id", b.irq_id, j);
        b.irq_ack = 1'b1; tick; b.irq_ack = 1'b0;
        e = 4'hf << (j + 1);
        chk("rr_pend", b.pend, e);
        chk("rr_gap", b.irq, 1'b0);
        tick; tick;
      end
      chk("rr_done_irq", b.irq, 1'b0);
    end
    // overrun on channel 1
    b.int_in = 4'b0010; tick; b.int_in = 4'b0000;
    chk("ov_pend", b.pend, 4'h2);
    tick;
    chk("ov_irq", b.irq, 1'b1);
    chk("ov_id", b.irq_id, 2'd1);
    b.int_in = 4'b0010; tick; b.int_in = 4'b0000;
    chk("ov_set", b.ovf, 4'h2);
    chk("ov_irq_hold", b.irq, 1'b1);
    chk("ov_id_hold", b.irq_id, 2'd1);
    b.irq_ack = 1'b1; tick; b.irq_ack = 1'b0;
    chk("ov_ack_pend", b.pend, 4'h0);
    tick; tick;
    chk("ov_single_irq", b.irq, 1'b0);
    b.ovf_clr = 4'b0010; tick; b.ovf_clr = 4'b0000;
    chk("ov_clr", b.ovf, 4'h0);
    b.int_in = 4'b0010; tick; b.int_in = 4'b0000; tick;
    chk("ov2_irq", b.irq, 1'b1);
    b.int_in = 4'b0010; b.ovf_clr = 4'b0010; tick; b.int_in = 4'b0000; b.ovf_clr = 4'b0000;
    chk("ov_set_wins", b.ovf, 4'h2);
    b.irq_ack = 1'b1; tick; b.irq_ack = 1'b0; tick; tick;
    b.ovf_clr = 4'b0010; tick; b.ovf_clr = 4'b0000;
    // ack coinciding with a new edge on the served channel
    b.int_in = 4'b0100; tick; b.int_in = 4'b0000; tick;
    chk("col_id", b.irq_id, 2'd2);
    b.irq_ack = 1'b1; b.int_in = 4'b0100; tick; b.irq_ack = 1'b0; b.int_in = 4'b0000;
    chk("col_pend", b.pend, 4'h4);
    chk("col_ovf", b.ovf, 4'h0);
    chk("col_gap", b.irq, 1'b0);
    tick;
    chk("col_idle", b.irq, 1'b0);
    tick;
    chk("col_reirq", b.irq, 1'b1);
    chk("col_reid", b.irq_id, 2'd2);
    // masking the served channel does not drop the request
    b.mask_wr = 1'b1; b.mask_wdata = 4'b1111; tick; b.mask_wr = 1'b0;
    chk("mskhold_irq", b.irq, 1'b1);
    chk("mskhold_id", b.irq_id, 2'd2);
    b.irq_ack = 1'b1; tick; b.irq_ack = 1'b0;
    chk("mskhold_ack", b.irq, 1'b0);
    tick; tick;
    // reset in the middle of an asserted request
    b.mask_wr = 1'b1; b.mask_wdata = 4'b0000; tick; b.mask_wr = 1'b0;
    b.int_in = 4'b0001; tick; b.int_in = 4'b0000; tick;
    chk("ra_irq", b.irq, 1'b1);
    b.int_in = 4'b0001; tick; b.int_in = 4'b0000;
    chk("ra_ovf", b.ovf, 4'h1);
    #2 xrst = 1'b0;
    #1;
    chk("ra_irq0", b.irq, 1'b0);
    chk("ra_pend0", b.pend, 4'h0);
    chk("ra_ovf0", b.ovf, 4'h0);
    chk("ra_mask", b.mask, 4'hf);
    chk("ra_id0", b.irq_id, 2'd0);
    tick; xrst = 1'b1;
    b.mask_wr = 1'b1; b.mask_wdata = 4'b0000; tick; b.mask_wr = 1'b0;
    b.int_in = 4'b0101; tick; b.int_in = 4'b0000; tick;
    chk("ra_first_irq", b.irq, 1'b1);
    chk("ra_first_id", b.irq_id, 2'd0);
    b.irq_ack = 1'b1; tick; b.irq_ack = 1'b0; tick; tick;
    chk("ra_next_id", b.irq_id, 2'd2);
    b.irq_ack = 1'b1; tick; b.irq_ack = 1'b0; tick; tick;
    // constant-high input raises a single event only
    b.int_in = 4'b0010; tick;
    chk("ch_pend", b.pend, 4'h2);
    tick;
    chk("ch_id", b.irq_id, 2'd1);
    b.irq_ack = 1'b1; tick; b.irq_ack = 1'b0; tick; tick; tick;
    chk("ch_pend_none", b.pend, 4'h0);
    chk("ch_ovf_none", b.ovf, 4'h0);
    chk("ch_irq_none", b.irq, 1'b0);
    b.int_in = 4'b0000;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cnt_int_ctrl.md
CNT_INT_CTRL -- requirements
Module: cnt_int_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4: number of counter channels whose int outputs are aggregated.
REQ-002 SHALL have parameter IDW, default 2: channel-index width, with NCH <= 2**IDW.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port xrst  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port int_in  input  NCH: per-channel int level from the counter channels.
REQ-006 SHALL have port mask_wr  input  1: single-cycle write strobe for the mask register.
REQ-007 SHALL have port mask_wdata  input  NCH: mask value, where 1 means the channel is masked.
REQ-008 SHALL have port ovf_clr  input  NCH: per-channel single-cycle clear pulse for ovf.
REQ-009 SHALL have port irq_ack  input  1: CPU acknowledge of the current request.
REQ-010 SHALL have port mask  output  NCH: current mask register.
REQ-011 SHALL have port pend  output  NCH: pending flags.
REQ-012 SHALL have port ovf  output  NCH: sticky overrun flags.
REQ-013 SHALL have port irq  output  1: interrupt request to the CPU.
REQ-014 SHALL have port irq_id  output  IDW: index of the channel being served, valid while irq=1.

Function
REQ-015 SHALL register int_in every cycle (int_d) and define edge[i] = int_in[i] & ~int_d[i] & ~mask[i].
REQ-016 SHALL set pend[i] on the edge after the cycle in which edge[i]=1, giving latency 1 from the sampled rise.
REQ-017 SHALL ignore an int_in rise on a masked channel entirely: no pend, no ovf, not replayed on unmask.
REQ-018 SHALL set ovf[i] when edge[i]=1 while pend[i]=1 and pend[i] is not being cleared that cycle.
REQ-019 SHALL clear ovf[i] on ovf_clr[i]=1; if set and clear occur in the same cycle, set wins.
REQ-020 SHALL load mask <= mask_wdata on mask_wr=1; the new mask applies to edge detection from the next cycle.
REQ-021 SHALL implement an FSM with states IDLE, ASSERT and GAP.
REQ-022 SHALL, in IDLE with eligible = pend & ~mask nonzero, select the channel round-robin, searching upward from (last+1) mod NCH; it SHALL register irq_id, set irq=1, and go to ASSERT.
REQ-023 SHALL hold irq=1 and irq_id constant in ASSERT until irq_ack=1, even if the channel becomes masked meanwhile.
REQ-024 SHALL, on irq_ack=1 in ASSERT, clear pend[irq_id], set last=irq_id and irq=0, and go to GAP.
REQ-025 SHALL keep pend[irq_id]=1 when an edge on that channel coincides with its ack (set wins), with no ovf raised.
REQ-026 SHALL stay in GAP for exactly 1 cycle with irq=0, then go to IDLE.
REQ-027 SHALL ignore irq_ack in IDLE and GAP.
REQ-028 SHALL give a minimum spacing of 3 cycles between irq rises for back-to-back requests.
REQ-029 SHALL produce irq=1 two edges after int_in is first sampled high: pend at edge k, irq at edge k+1.
REQ-030 SHALL set no pend and no ovf for a constant-high int_in (counter cnt_val=0) beyond its first rise.

Reset
REQ-031 SHALL, when xrst=0, immediately clear int_d, pend, ovf, irq and irq_id to 0, set mask to all ones, set state to IDLE and set last to NCH-1, so the first search starts at channel 0.
REQ-032 SHALL abort an in-flight request on reset mid-ASSERT without requiring an ack.
REQ-033 SHALL treat int_in already high at the first sample after reset release as an edge if that channel is unmasked.

Verification
REQ-034 SHALL cover single event: mask=0, one-cycle pulse on int_in[2] -> pend=0100 next edge, irq=1 with irq_id=2 one edge later; ack -> pend=0000, irq=0 for 1 cycle.
REQ-035 SHALL cover round-robin: int_in=1111 pulsed together, each ack given at once -> irq_id sequence 0,1,2,3; then repeat from last=3 -> 0,1,2,3.
REQ-036 SHALL cover overrun: int_in[1] pulsed twice before ack -> ovf=0010, single irq; ovf_clr[1] -> ovf=0000; ovf_clr coincident with a new overrun edge -> ovf stays 0010.
REQ-037 SHALL cover mask: reset mask=1111, pulse int_in[0] -> no pend, no irq; write mask=1110, hold int_in[3] high -> no event; pulse int_in[0] -> irq_id=0.
REQ-038 SHALL cover ack/edge collision: edge on int_in[2] in the same cycle as ack of irq_id=2 -> pend[2] stays 1, ovf[2]=0, after GAP irq=1 with irq_id=2 again.
REQ-039 SHALL cover reset mid-ASSERT: assert xrst=0 while irq=1 -> irq, pend, ovf=0 and mask=1111 immediately; after release the first service starts at channel 0.
